// File: rtl/wave_gen_if.sv
// Sample/command bus between wave_gen and the DAC serializer.
// The master (wave_gen) drives value/command/valid; the slave answers with ready.
interface wave_gen_if #(
    parameter int OUT_W = 16
);
    logic [OUT_W-1:0] value;
    logic [15:0]      command;
    logic             valid;
    logic             ready;

    modport master (output value, output command, output valid, input ready);
    modport slave  (input value, input command, input valid, output ready);
endinterface

// File: rtl/wave_gen.sv
// wave_gen: paced waveform sample generator (ramp / triangle / square / hold)
// feeding the DAC serializer over a valid/ready handshake.
// Optional build macro: WAVE_GEN_OVERRUN_EN adds a sticky overrun flag that is set
// whenever a tick is skipped because the output slot is still occupied.
//
// Triangle direction state:
//   state    | meaning
//   DIR_UP   | accumulator climbing towards hi (also the state after any restart)
//   DIR_DOWN | accumulator descending towards lo
module wave_gen #(
    parameter int          DATA_W = 12,
    parameter int          OUT_W  = 16,
    parameter int          DIV_W  = 5,
    parameter logic [15:0] CMD    = 16'h0C00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] step,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    output logic              overrun,
    wave_gen_if.master        dac
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    localparam logic [1:0] MODE_RAMP   = 2'd0;
    localparam logic [1:0] MODE_TRI    = 2'd1;
    localparam logic [1:0] MODE_SQUARE = 2'd2;

    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [DATA_W-1:0] acc_q, acc_d, acc_nxt;
    dir_t              dir_q, dir_d, dir_nxt;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic [OUT_W-1:0]  value_q, value_d;
    logic [1:0]        mode_q, mode_d;

    logic              tick, slot_free, start_eff;
    logic [DATA_W:0]   sum_up, lo_plus;

    // Prescaler compare; a live div below the count simply lets it run up and wrap.
    always_comb begin
        tick    = enable && (presc_q == div);
        presc_d = '0;
        if (enable && !tick) begin
            presc_d = presc_q + DIV_W'(1);
        end
    end

    // Candidate accumulator/direction for the next accepted tick (one extra bit, no wrap).
    always_comb begin
        sum_up    = {1'b0, acc_q} + {1'b0, step};
        lo_plus   = {1'b0, lo} + {1'b0, step};
        start_eff = start_q || (mode != mode_q);
        acc_nxt   = lo;
        dir_nxt   = dir_q;
        if (start_eff) begin
            dir_nxt = DIR_UP;
        end else if (lo <= hi) begin
            case (mode)
                MODE_RAMP: begin
                    if (step != '0 && sum_up <= {1'b0, hi}) begin
                        acc_nxt = sum_up[DATA_W-1:0];
                    end
                end
                MODE_TRI: begin
                    if (step != '0) begin
                        if (dir_q == DIR_UP) begin
                            if (sum_up >= {1'b0, hi}) begin
                                acc_nxt = hi;
                                dir_nxt = DIR_DOWN;
                            end else begin
                                acc_nxt = sum_up[DATA_W-1:0];
                            end
                        end else if ({1'b0, acc_q} < lo_plus) begin
                            dir_nxt = DIR_UP;
                        end else begin
                            acc_nxt = acc_q - step;
                        end
                    end
                end
                MODE_SQUARE: acc_nxt = (acc_q == lo) ? hi : lo;
                default:     acc_nxt = lo;
            endcase
        end
    end

    // Output slot handshake: accept a tick only when the slot is free or draining now.
    always_comb begin
        slot_free = !valid_q || dac.ready;
        acc_d     = acc_q;
        dir_d     = dir_q;
        value_d   = value_q;
        valid_d   = valid_q;
        start_d   = start_eff;
        mode_d    = mode;
        if (tick && slot_free) begin
            acc_d   = acc_nxt;
            dir_d   = dir_nxt;
            value_d = OUT_W'(acc_nxt);
            valid_d = 1'b1;
            start_d = 1'b0;
        end else if (valid_q && dac.ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            acc_q   <= '0;
            dir_q   <= DIR_UP;
            start_q <= 1'b1;
            valid_q <= 1'b0;
            value_q <= '0;
            mode_q  <= '0;
        end else begin
            presc_q <= presc_d;
            acc_q   <= acc_d;
            dir_q   <= dir_d;
            start_q <= start_d;
            valid_q <= valid_d;
            value_q <= value_d;
            mode_q  <= mode_d;
        end
    end

`ifdef WAVE_GEN_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky flag: set by any tick lost to backpressure, cleared only by reset.
    always_comb begin
        overrun_d = overrun_q || (tick && !slot_free);
    end

    // Overrun register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign dac.value   = value_q;
    assign dac.valid   = valid_q;
    assign dac.command = CMD;

endmodule

// File: tb/tb_wave_gen.sv
// Directed bench for wave_gen: a sequence-level model checks every cycle,
// hand-computed sample lists pin the model and the DUT.
module tb_wave_gen;
    localparam int DATA_W = 12;
    localparam int OUT_W  = 16;
    localparam int DIV_W  = 5;

    logic              clk    = 1'b0;
    logic              reset  = 1'b0;
    logic              enable = 1'b0;
    logic [1:0]        mode   = 2'd0;
    logic [DIV_W-1:0]  div    = '0;
    logic [DATA_W-1:0] step   = '0;
    logic [DATA_W-1:0] lo     = '0;
    logic [DATA_W-1:0] hi     = '0;
    logic              overrun;

    wave_gen_if #(.OUT_W(OUT_W)) dac_if ();

    wave_gen #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DIV_W(DIV_W), .CMD(16'h0C00)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .mode    (mode),
        .div     (div),
        .step    (step),
        .lo      (lo),
        .hi      (hi),
        .overrun (overrun),
        .dac     (dac_if)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int got[$];
    int got_t[$];
    int exp_q[$];

    // model state: one period of the current waveform plus a position in it
    int seq[$];
    int m_idx   = 0;
    int m_val   = 0;
    int m_presc = 0;
    int m_prev  = 0;
    bit m_valid = 1'b0;
    bit m_start = 1'b1;
    bit m_ovr   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One period of the waveform as a plain list of values.
    function automatic void build_seq(input int md, input int l, input int h, input int s);
        int v;
        seq.delete();
        if (l > h || md == 3 || ((md == 0 || md == 1) && s == 0)) begin
            seq.push_back(l);
        end else if (md == 0) begin
            v = l;
            while (v <= h) begin
                seq.push_back(v);
                v += s;
            end
        end else if (md == 1) begin
            v = l;
            seq.push_back(l);
            forever begin
                if (v + s >= h) begin
                    seq.push_back(h);
                    break;
                end
                v += s;
                seq.push_back(v);
            end
            v = h;
            while (!(v < l + s)) begin
                v -= s;
                seq.push_back(v);
            end
        end else begin
            seq.push_back(l);
            seq.push_back(h);
        end
    endfunction

    // Model advance at each edge, then compare the DUT against it.
    initial begin
        bit tick, free, st;
        int exp_ovr;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_idx = 0; m_val = 0; m_presc = 0; m_prev = 0;
                m_valid = 1'b0; m_start = 1'b1; m_ovr = 1'b0;
            end else begin
                tick = enable && (m_presc == int'(div));
                free = !m_valid || dac_if.ready;
                st   = m_start || (int'(mode) != m_prev);
                if (tick && free) begin
                    if (st) begin
                        build_seq(int'(mode), int'(lo), int'(hi), int'(step));
                        m_idx = 0;
                    end else begin
                        m_idx = (m_idx + 1) % seq.size();
                    end
                    m_val   = seq[m_idx];
                    m_valid = 1'b1;
                    m_start = 1'b0;
                end else begin
                    if (tick) m_ovr = 1'b1;
                    m_start = st;
                    if (m_valid && dac_if.ready) m_valid = 1'b0;
                end
                m_prev = int'(mode);
                if (!enable || m_presc == int'(div)) m_presc = 0;
                else m_presc = (m_presc + 1) % (1 << DIV_W);
            end
            #1;
`ifdef WAVE_GEN_OVERRUN_EN
            exp_ovr = int'(m_ovr);
`else
            exp_ovr = 0;
`endif
            check("valid", int'(dac_if.valid), int'(m_valid));
            if (m_valid) check("value", int'(dac_if.value), m_val);
            check("overrun", int'(overrun), exp_ovr);
            check("command", int'(dac_if.command), 16'h0C00);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transfer, sampled mid-cycle once ready is settled.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset && dac_if.valid && dac_if.ready) begin
                got.push_back(int'(dac_if.value));
                got_t.push_back(cyc);
            end
        end
    end

    task automatic wait_samples(input int n, input int budget, input string name);
        int c = 0;
        while (got.size() < n && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        if (got.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d samples, want %0d", name, got.size(), n);
        end
    endtask

    task automatic check_got(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                check($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL %s[%0d]: got no sample, want %0d", name, i, exp_q[i]);
            end
        end
    endtask

    task automatic drain();
        enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        dac_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_value", int'(dac_if.value), 0);
        check("rst_valid", int'(dac_if.valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_command", int'(dac_if.command), 16'h0C00);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_samples", got.size(), 0);

        // ramp with wrap, 32-clock period
        div = 5'd31; lo = 12'd0; hi = 12'd10; step = 12'd4; mode = 2'd0;
        got.delete(); got_t.delete();
        enable = 1'b1;
        wait_samples(5, 5 * 32 + 40, "ramp");
        exp_q = '{0, 4, 8, 0, 4};
        check_got("ramp");
        for (int i = 1; i < 5; i++) begin
            if (i < got_t.size()) check("ramp_period", got_t[i] - got_t[i-1], 32);
        end
        drain();

        // triangle, back-to-back
        mode = 2'd1; div = '0; lo = 12'd2; hi = 12'd9; step = 12'd3;
        got.delete();
        enable = 1'b1;
        wait_samples(8, 40, "tri");
        exp_q = '{2, 5, 8, 9, 6, 3, 2, 5};
        check_got("tri");
        drain();

        // square for exactly three ticks, then a mode change restarts at lo
        mode = 2'd2; lo = 12'd1; hi = 12'd7;
        got.delete();
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("square_count", got.size(), 3);
        exp_q = '{1, 7, 1};
        check_got("square");
        @(negedge clk);
        mode = 2'd0; step = 12'd6;
        got.delete();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        exp_q = '{1};
        check_got("mode_restart");

        // backpressure: ready low while ticks keep coming
        @(negedge clk);
        mode = 2'd3;
        repeat (2) @(negedge clk);
        mode = 2'd0; lo = 12'd0; hi = 12'd100; step = 12'd5; div = '0;
        dac_if.ready = 1'b0;
        got.delete();
        enable = 1'b1;
        repeat (6) @(negedge clk);
        check("bp_value", int'(dac_if.value), 0);
        check("bp_valid", int'(dac_if.valid), 1);
`ifdef WAVE_GEN_OVERRUN_EN
        check("bp_overrun", int'(overrun), 1);
`else
        check("bp_overrun", int'(overrun), 0);
`endif
        got.delete();
        dac_if.ready = 1'b1;
        wait_samples(2, 10, "bp");
        exp_q = '{0, 5};
        check_got("bp_resume");
        drain();

        // lo > hi behaves as hold
        mode = 2'd1; lo = 12'd8; hi = 12'd3; step = 12'd2;
        got.delete();
        enable = 1'b1;
        wait_samples(4, 20, "degen");
        exp_q = '{8, 8, 8, 8};
        check_got("degen");

        // asynchronous reset mid-stream, then restart at lo
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_valid", int'(dac_if.valid), 0);
        check("midrst_value", int'(dac_if.value), 0);
        check("midrst_overrun", int'(overrun), 0);
        @(negedge clk);
        lo = 12'd2; hi = 12'd9; step = 12'd3;
        got.delete();
        reset = 1'b1;
        wait_samples(3, 20, "restart");
        exp_q = '{2, 5, 8};
        check_got("restart");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wave_gen.md
# wave_gen

Parametrised sample generator that drives the DAC serializer path with a paced stream of data words plus a fixed DAC command word. A programmable prescaler sets the sample rate. Each sample follows a selectable waveform (ramp, triangle, square or hold) between programmable limits. Samples go downstream over a valid/ready handshake, so a slow serializer stalls the generator instead of silently losing samples.

## Interface
Parameters:
- DATA_W, 12, width of the sample accumulator and of lo/hi/step
- OUT_W, 16, width of value; the sample is zero-extended to this width (OUT_W >= DATA_W)
- DIV_W, 5, width of the prescaler and of div
- CMD, 16'h0C00, constant driven on command

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = prescaler runs; 0 = prescaler held at 0, no new samples
- mode  in  2  0 ramp, 1 triangle, 2 square, 3 hold
- div  in  DIV_W  tick period is div+1 clocks
- step  in  DATA_W  increment per tick (ramp/triangle)
- lo  in  DATA_W  lower limit
- hi  in  DATA_W  upper limit
- value  out  OUT_W  current sample, registered
- command  out  16  constant CMD
- valid  out  1  value holds an unconsumed sample
- ready  in  1  downstream accepts value when valid && ready
- overrun  out  1  sticky; a tick was skipped due to backpressure

## Operation
- Reset (reset = 0): prescaler = 0, accumulator = 0, direction = up, start flag = 1, valid = 0, value = 0, overrun = 0. command always = CMD.
- Prescaler: when enable = 1 it counts 0..div, then wraps to 0. tick = enable && (presc == div). With div = 0, every enabled cycle is a tick.
- On tick with the output slot free (valid = 0, or valid && ready in the same cycle):
  - The accumulator updates.
  - value <= zero-extended new accumulator.
  - valid <= 1.
- On tick with the slot occupied (valid && !ready):
  - No update; the accumulator and direction hold.
  - overrun <= 1.
- valid && ready without a tick: valid <= 0.
- Accumulator update rules. All sums use DATA_W+1 bits, so there is no silent wrap.
  - Start flag set (first tick after reset or after any mode change): acc <= lo, direction = up, start flag cleared.
  - Ramp: if acc+step > hi then acc <= lo, else acc <= acc+step.
  - Triangle, direction up: if acc+step >= hi then acc <= hi and direction goes down, else acc <= acc+step.
  - Triangle, direction down: if acc < lo+step then acc <= lo and direction goes up, else acc <= acc-step.
  - Square: acc <= (acc == lo) ? hi : lo.
  - Hold: acc <= lo.
- Degenerate limits: if lo > hi, every mode behaves as hold. step = 0 in ramp or triangle holds acc at lo.
- A mode change sets the start flag. It is detected by comparing mode against a registered copy each cycle.
- lo, hi, step and div are sampled live. A change takes effect at the next tick or prescaler compare.
- If div is reduced below the current prescaler count, the prescaler runs up to its maximum, wraps to 0, then compares normally.

## Timing
- Sample latency: value and valid change on the clock edge that ends the tick cycle, i.e. they are visible 1 cycle after presc == div.
- Handshake: value is stable while valid && !ready. Transfer occurs in any cycle with valid && ready. Back-to-back transfers are possible when div = 0.
- Sample period at steady state with ready = 1 is div+1 clocks.
- Asynchronous reset clears all state immediately, including a pending sample mid-handshake. Deassertion is expected synchronous to clk.
- enable falling with valid = 1: the pending sample stays valid until accepted.

## Configuration
- WAVE_GEN_OVERRUN_EN:
  - Defined: the overrun flag is implemented, set as described above, and cleared only by reset.
  - Undefined: overrun is tied to 0 and no overrun logic is built. Stall behaviour (skip tick, hold accumulator) is identical in both builds.

## Test plan
- Reset defaults: reset = 0 then 1, enable = 0 -> value = 0, valid = 0, overrun = 0, command = 16'h0C00; no valid for 100 cycles.
- Ramp with wrap: div = 31, lo = 0, hi = 10, step = 4, ready = 1 -> values 0, 4, 8, 0, 4, ..., with valid pulses exactly 32 clocks apart.
- Triangle: div = 0, lo = 2, hi = 9, step = 3 -> values 2, 5, 8, 9, 6, 3, 2, 5, ...
- Square, then mode change: mode = 2, lo = 1, hi = 7 -> 1, 7, 1. Switch to mode 0 -> the next sample is lo = 1.
- Backpressure: div = 0, ramp, ready = 0 for 5 cycles -> value frozen at its first sample, accumulator not advanced, overrun = 1 (0 when WAVE_GEN_OVERRUN_EN is undefined). When ready returns, the next value is first sample + step.
- Edge limits: lo = 8, hi = 3 in triangle -> constant 8. A reset pulse mid-stream -> valid = 0 and value = 0 immediately, then restart at lo.
